// File: rtl/xconnect_loader_if.sv
// Purpose: stream, configuration and launch signals between xconnect_loader and its neighbours.
// Signals:
//   in_valid / in_ready / in_data    - serial PE word stream into the loader
//   cfg_valid / cfg_groups_sizes     - per-PE groups-size configuration
//   input_pes_data / groups_sizes    - launched batch presented to xconnect
//   xc_start / xc_busy / cfg_error   - launch pulse, hold indicator, sticky cfg reject flag
// Modports: slave = loader side, master = feeder / xconnect side.
interface xconnect_loader_if #(
    parameter int unsigned WORD_SIZE        = 256,
    parameter int unsigned NOF_PES          = 16,
    parameter int unsigned GROUP_SIZE_WIDTH = $clog2(NOF_PES) + 1
) ();

    logic                                  in_valid;
    logic                                  in_ready;
    logic [WORD_SIZE-1:0]                  in_data;
    logic                                  cfg_valid;
    logic [GROUP_SIZE_WIDTH*NOF_PES-1:0]   cfg_groups_sizes;
    logic [WORD_SIZE*NOF_PES-1:0]          input_pes_data;
    logic [GROUP_SIZE_WIDTH*NOF_PES-1:0]   groups_sizes;
    logic                                  xc_start;
    logic                                  xc_busy;
    logic                                  cfg_error;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  cfg_valid,
        input  cfg_groups_sizes,
        output input_pes_data,
        output groups_sizes,
        output xc_start,
        output xc_busy,
        output cfg_error
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output cfg_valid,
        output cfg_groups_sizes,
        input  input_pes_data,
        input  groups_sizes,
        input  xc_start,
        input  xc_busy,
        input  cfg_error
    );

endinterface

// File: rtl/xconnect_loader.sv
// Purpose: double-buffered upstream feeder for xconnect. Serially collects NOF_PES
// words into a shadow buffer, keeps a validated groups-size configuration, and
// launches complete batches onto registered outputs, holding each for HOLD_CYCLES.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - xconnect_loader_if.slave (word stream, cfg, launched batch, status)
module xconnect_loader #(
    parameter int unsigned WORD_SIZE        = 256,
    parameter int unsigned NOF_PES          = 16,
    parameter int unsigned NOF_LEVELS       = $clog2(NOF_PES),
    parameter int unsigned GROUP_SIZE_WIDTH = NOF_LEVELS + 1,
    parameter int unsigned HOLD_CYCLES      = NOF_LEVELS
) (
    input  logic             clk,
    input  logic             rst,
    xconnect_loader_if.slave bus
);

    localparam int unsigned IDX_W  = (NOF_PES > 1) ? $clog2(NOF_PES) : 1;
    localparam int unsigned HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned DATA_W = WORD_SIZE * NOF_PES;
    localparam int unsigned CFG_W  = GROUP_SIZE_WIDTH * NOF_PES;

    localparam logic [IDX_W-1:0]            LAST_IDX  = IDX_W'(NOF_PES - 1);
    localparam logic [HCNT_W-1:0]           LAST_HOLD = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [GROUP_SIZE_WIDTH-1:0] MAX_GS    = GROUP_SIZE_WIDTH'(NOF_PES);
    localparam logic [GROUP_SIZE_WIDTH-1:0] GS_ONE    = GROUP_SIZE_WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e              state_q,        state_d;
    logic [HCNT_W-1:0]   hold_cnt_q,     hold_cnt_d;
    logic [IDX_W-1:0]    wr_idx_q,       wr_idx_d;
    logic                shadow_full_q,  shadow_full_d;
    logic [DATA_W-1:0]   shadow_data_q,  shadow_data_d;
    logic [CFG_W-1:0]    shadow_cfg_q,   shadow_cfg_d;
    logic                cfg_seen_q,     cfg_seen_d;
    logic                cfg_error_q,    cfg_error_d;
    logic [DATA_W-1:0]   pes_data_q,     pes_data_d;
    logic [CFG_W-1:0]    gs_q,           gs_d;
    logic                xc_start_q,     xc_start_d;
    logic                xc_busy_q,      xc_busy_d;

    logic                in_ready;
    logic                accept;
    logic                launch;
    logic                cfg_legal;

    // Ready depends only on buffer occupancy; a held batch never stalls the stream.
    assign in_ready = !rst && !shadow_full_q;
    assign accept   = bus.in_valid && in_ready;

    // A full shadow launches from IDLE or on the last hold cycle (back-to-back relaunch).
    assign launch = shadow_full_q && cfg_seen_q &&
                    ((state_q == IDLE) || ((state_q == HOLD) && (hold_cnt_q == LAST_HOLD)));

    // Every field must be a power of two no larger than NOF_PES.
    always_comb begin
        logic [GROUP_SIZE_WIDTH-1:0] field;
        cfg_legal = 1'b1;
        field     = '0;
        for (int unsigned p = 0; p < NOF_PES; p++) begin
            field = bus.cfg_groups_sizes[p*GROUP_SIZE_WIDTH +: GROUP_SIZE_WIDTH];
            if ((field == '0) || ((field & (field - GS_ONE)) != '0) || (field > MAX_GS)) begin
                cfg_legal = 1'b0;
            end
        end
    end

    // Next-state: shadow fill, cfg capture, hold sequencing and launch.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        wr_idx_d      = wr_idx_q;
        shadow_full_d = shadow_full_q;
        shadow_data_d = shadow_data_q;
        shadow_cfg_d  = shadow_cfg_q;
        cfg_seen_d    = cfg_seen_q;
        cfg_error_d   = cfg_error_q;
        pes_data_d    = pes_data_q;
        gs_d          = gs_q;
        xc_start_d    = 1'b0;
        xc_busy_d     = xc_busy_q;

        if (accept) begin
            shadow_data_d[wr_idx_q*WORD_SIZE +: WORD_SIZE] = bus.in_data;
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d      = '0;
                shadow_full_d = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end

        // A rejected cfg leaves the previous shadow cfg untouched.
        if (bus.cfg_valid) begin
            if (cfg_legal) begin
                shadow_cfg_d = bus.cfg_groups_sizes;
                cfg_seen_d   = 1'b1;
            end else begin
                cfg_error_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                xc_busy_d = 1'b0;
            end
            HOLD: begin
                if (hold_cnt_q == LAST_HOLD) begin
                    state_d   = IDLE;
                    xc_busy_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                xc_busy_d = 1'b0;
            end
        endcase

        // Launch overrides the hold bookkeeping; outputs take the pre-update shadow cfg.
        if (launch) begin
            pes_data_d    = shadow_data_q;
            gs_d          = shadow_cfg_q;
            shadow_full_d = 1'b0;
            wr_idx_d      = '0;
            xc_start_d    = 1'b1;
            state_d       = HOLD;
            hold_cnt_d    = '0;
            xc_busy_d     = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            wr_idx_q      <= '0;
            shadow_full_q <= 1'b0;
            shadow_data_q <= '0;
            shadow_cfg_q  <= '0;
            cfg_seen_q    <= 1'b0;
            cfg_error_q   <= 1'b0;
            pes_data_q    <= '0;
            gs_q          <= '0;
            xc_start_q    <= 1'b0;
            xc_busy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            wr_idx_q      <= wr_idx_d;
            shadow_full_q <= shadow_full_d;
            shadow_data_q <= shadow_data_d;
            shadow_cfg_q  <= shadow_cfg_d;
            cfg_seen_q    <= cfg_seen_d;
            cfg_error_q   <= cfg_error_d;
            pes_data_q    <= pes_data_d;
            gs_q          <= gs_d;
            xc_start_q    <= xc_start_d;
            xc_busy_q     <= xc_busy_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.input_pes_data = pes_data_q;
    assign bus.groups_sizes   = gs_q;
    assign bus.xc_start       = xc_start_q;
    assign bus.xc_busy        = xc_busy_q;
    assign bus.cfg_error      = cfg_error_q;

endmodule

// File: tb/tb_xconnect_loader.sv
// Purpose: self-checking bench for xconnect_loader. A batch-level reference model
// (queue of accepted words, current cfg, remaining hold cycles) predicts every
// cycle's outputs; directed steps add targeted checks. A second small instance
// with a long hold exercises back-to-back relaunch.
module tb_xconnect_loader;

    localparam int unsigned WS  = 256;
    localparam int unsigned NP  = 16;
    localparam int unsigned NL  = 4;
    localparam int unsigned GSW = 5;
    localparam int unsigned H   = 4;

    localparam int unsigned W2  = 8;
    localparam int unsigned P2  = 4;
    localparam int unsigned G2  = 3;
    localparam int unsigned H2  = 6;

    typedef logic [WS-1:0]     word_t;
    typedef logic [GSW*NP-1:0] cfg_t;
    typedef logic [WS*NP-1:0]  data_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    xconnect_loader_if #(.WORD_SIZE(WS), .NOF_PES(NP), .GROUP_SIZE_WIDTH(GSW)) bus ();
    xconnect_loader_if #(.WORD_SIZE(W2), .NOF_PES(P2), .GROUP_SIZE_WIDTH(G2))  bus2 ();

    xconnect_loader #(
        .WORD_SIZE(WS), .NOF_PES(NP), .NOF_LEVELS(NL),
        .GROUP_SIZE_WIDTH(GSW), .HOLD_CYCLES(H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    xconnect_loader #(
        .WORD_SIZE(W2), .NOF_PES(P2), .NOF_LEVELS(2),
        .GROUP_SIZE_WIDTH(G2), .HOLD_CYCLES(H2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int    checks = 0;
    int    errors = 0;

    // Reference model state
    word_t m_buf[$];
    cfg_t  m_cfg;
    bit    m_cfg_ok;
    bit    m_err;
    int    m_hold_left;
    data_t exp_data;
    cfg_t  exp_gs;
    bit    exp_start;
    bit    exp_busy;

    // Observation counters
    int    cyc_no;
    int    obs_starts;
    int    obs_busy;
    int    first_start;
    int    last_start;
    bit    acc;

    function automatic bit legal_field(int v);
        for (int k = 0; (1 << k) <= int'(NP); k++) begin
            if (v == (1 << k)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit legal_cfg(cfg_t c);
        for (int p = 0; p < int'(NP); p++) begin
            if (!legal_field(int'(c[p*GSW +: GSW]))) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic cfg_t fill_cfg(int v);
        cfg_t c;
        c = '0;
        for (int p = 0; p < int'(NP); p++) c[p*GSW +: GSW] = GSW'(v);
        return c;
    endfunction

    function automatic data_t pack_buf();
        data_t d;
        d = '0;
        for (int k = 0; k < m_buf.size(); k++) d[k*WS +: WS] = m_buf[k];
        return d;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < int'(WS / 32); i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_no);
        end
    endtask

    task automatic chk_data(input string tag, input data_t act, input data_t exp);
        int slot;
        slot = 0;
        checks++;
        assert (act === exp) else begin
            errors++;
            for (int k = int'(NP) - 1; k >= 0; k--) begin
                if (act[k*WS +: WS] !== exp[k*WS +: WS]) slot = k;
            end
            $error("FAIL %s: slot %0d got %h expected %h (cycle %0d)",
                   tag, slot, act[slot*WS +: WS], exp[slot*WS +: WS], cyc_no);
        end
    endtask

    // One clock: drive inputs, check ready, advance model at the edge, check outputs.
    task automatic cyc(input bit v, input word_t d, input bit cv, input cfg_t c,
                       input bit r, output bit accepted);
        bit exp_ready;
        bit launch;
        bus.in_valid         = v;
        bus.in_data          = d;
        bus.cfg_valid        = cv;
        bus.cfg_groups_sizes = c;
        rst                  = r;
        #1;
        exp_ready = !r && (m_buf.size() < int'(NP));
        chk("in_ready", 128'(bus.in_ready), 128'(exp_ready));
        accepted = v && exp_ready;
        @(posedge clk);
        if (r) begin
            m_buf.delete();
            m_cfg       = '0;
            m_cfg_ok    = 1'b0;
            m_err       = 1'b0;
            m_hold_left = 0;
            exp_data    = '0;
            exp_gs      = '0;
            exp_start   = 1'b0;
            exp_busy    = 1'b0;
        end else begin
            launch = (m_buf.size() == int'(NP)) && m_cfg_ok && (m_hold_left <= 1);
            if (launch) begin
                exp_data    = pack_buf();
                exp_gs      = m_cfg;
                m_buf.delete();
                exp_start   = 1'b1;
                m_hold_left = int'(H);
            end else begin
                exp_start = 1'b0;
                if (m_hold_left > 0) m_hold_left--;
            end
            exp_busy = (m_hold_left > 0);
            if (cv) begin
                if (legal_cfg(c)) begin
                    m_cfg    = c;
                    m_cfg_ok = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (accepted) m_buf.push_back(d);
        end
        #1;
        cyc_no++;
        chk("xc_start", 128'(bus.xc_start), 128'(exp_start));
        chk("xc_busy", 128'(bus.xc_busy), 128'(exp_busy));
        chk("cfg_error", 128'(bus.cfg_error), 128'(m_err));
        chk("groups_sizes", 128'(bus.groups_sizes), 128'(exp_gs));
        chk_data("input_pes_data", bus.input_pes_data, exp_data);
        if (bus.xc_start === 1'b1) begin
            obs_starts++;
            if (first_start < 0) first_start = cyc_no;
            last_start = cyc_no;
        end
        if (bus.xc_busy === 1'b1) obs_busy++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0, a);
    endtask

    task automatic do_reset();
        bit a;
        cyc(1'b0, '0, 1'b0, '0, 1'b1, a);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, a);
    endtask

    task automatic clear_obs();
        obs_starts  = 0;
        obs_busy    = 0;
        first_start = -1;
        last_start  = -1;
    endtask

    // Push n words valued base..base+n-1 on consecutive cycles, holding a word until accepted.
    task automatic stream(input int base, input int n);
        int  k;
        int  guard;
        bit  a;
        k     = 0;
        guard = 0;
        while (k < n && guard < 200) begin
            cyc(1'b1, word_t'(base + k), 1'b0, '0, 1'b0, a);
            if (a) k++;
            guard++;
        end
        chk("stream_done", 128'(k), 128'(n));
    endtask

    function automatic data_t ramp(int base);
        data_t d;
        for (int k = 0; k < int'(NP); k++) d[k*WS +: WS] = word_t'(base + k);
        return d;
    endfunction

    int   k2;
    int   s2_starts, s2_first, s2_last, s2_busy_low;
    bit   acc2;
    cfg_t bad_cfg;
    cfg_t rc;
    int   fv;

    initial begin
        cyc_no               = 0;
        bus.in_valid         = 1'b0;
        bus.in_data          = '0;
        bus.cfg_valid        = 1'b0;
        bus.cfg_groups_sizes = '0;
        bus2.in_valid        = 1'b0;
        bus2.in_data         = '0;
        bus2.cfg_valid       = 1'b0;
        bus2.cfg_groups_sizes = '0;
        rst                  = 1'b1;
        clear_obs();

        // 1) reset, cfg all 4, words 0..15 -> one launch, 4-cycle hold
        do_reset();
        chk("reset_ready", 128'(bus.in_ready), 128'(0));
        cyc(1'b0, '0, 1'b1, fill_cfg(4), 1'b0, acc);
        clear_obs();
        stream(0, int'(NP));
        idle(8);
        chk("s1_starts", 128'(obs_starts), 128'(1));
        chk("s1_busy_cycles", 128'(obs_busy), 128'(H));
        chk_data("s1_data", bus.input_pes_data, ramp(0));
        chk("s1_gs", 128'(bus.groups_sizes), 128'(fill_cfg(4)));

        // 2) back-to-back relaunch on the long-hold instance
        do_reset();
        bus2.cfg_valid        = 1'b1;
        bus2.cfg_groups_sizes = 12'h249;
        idle(1);
        bus2.cfg_valid        = 1'b0;
        k2 = 0; s2_starts = 0; s2_first = -1; s2_last = -1; s2_busy_low = 0;
        for (int t = 0; t < 30; t++) begin
            bus2.in_valid = (k2 < 2 * int'(P2));
            bus2.in_data  = W2'(8'h10 + k2);
            acc2 = bus2.in_valid && (bus2.in_ready === 1'b1);
            idle(1);
            if (acc2) k2++;
            if (bus2.xc_start === 1'b1) begin
                s2_starts++;
                if (s2_first < 0) s2_first = t;
                else              s2_last  = t;
            end else if (s2_first >= 0 && s2_last < 0 && bus2.xc_busy !== 1'b1) begin
                s2_busy_low++;
            end
        end
        bus2.in_valid = 1'b0;
        chk("b2b_starts", 128'(s2_starts), 128'(2));
        chk("b2b_gap", 128'(s2_last - s2_first), 128'(H2));
        chk("b2b_busy_gap", 128'(s2_busy_low), 128'(0));
        chk("b2b_data", 128'(bus2.input_pes_data), 128'(32'h17161514));
        chk("b2b_gs", 128'(bus2.groups_sizes), 128'(12'h249));

        // 3) 16 words without cfg: stalls; cfg all 16 then launches next edge
        do_reset();
        clear_obs();
        stream(100, int'(NP));
        idle(3);
        chk("nocfg_ready", 128'(bus.in_ready), 128'(0));
        chk("nocfg_starts", 128'(obs_starts), 128'(0));
        cyc(1'b0, '0, 1'b1, fill_cfg(16), 1'b0, acc);
        chk("cfg_edge_start", 128'(bus.xc_start), 128'(0));
        idle(1);
        chk("late_cfg_start", 128'(bus.xc_start), 128'(1));
        chk("late_cfg_gs", 128'(bus.groups_sizes), 128'(fill_cfg(16)));
        chk_data("late_cfg_data", bus.input_pes_data, ramp(100));
        idle(6);

        // 4) continuous 32 words; refill takes NOF_PES accepts after the launch edge
        do_reset();
        cyc(1'b0, '0, 1'b1, fill_cfg(2), 1'b0, acc);
        clear_obs();
        stream(0, 2 * int'(NP));
        idle(8);
        chk("cont_starts", 128'(obs_starts), 128'(2));
        chk("cont_gap", 128'(last_start - first_start), 128'(NP + 1));
        chk_data("cont_data", bus.input_pes_data, ramp(16));

        // 5) illegal cfg (3 at PE 5) rejected; later legal cfg accepted, error sticky
        do_reset();
        bad_cfg = fill_cfg(2);
        bad_cfg[5*GSW +: GSW] = GSW'(3);
        cyc(1'b0, '0, 1'b1, bad_cfg, 1'b0, acc);
        chk("bad_cfg_err", 128'(bus.cfg_error), 128'(1));
        chk("bad_cfg_gs", 128'(bus.groups_sizes), 128'(0));
        cyc(1'b0, '0, 1'b1, fill_cfg(8), 1'b0, acc);
        stream(40, int'(NP));
        idle(6);
        chk("good_after_bad_gs", 128'(bus.groups_sizes), 128'(fill_cfg(8)));
        chk("err_sticky", 128'(bus.cfg_error), 128'(1));

        // 6) reset mid-hold with partial words, then a full batch is required again
        do_reset();
        cyc(1'b0, '0, 1'b1, fill_cfg(1), 1'b0, acc);
        stream(200, int'(NP));
        idle(1);
        stream(300, 3);
        chk("midhold_busy", 128'(bus.xc_busy), 128'(1));
        cyc(1'b0, '0, 1'b0, '0, 1'b1, acc);
        chk_data("rst_data", bus.input_pes_data, '0);
        chk("rst_busy", 128'(bus.xc_busy), 128'(0));
        cyc(1'b0, '0, 1'b1, fill_cfg(2), 1'b0, acc);
        clear_obs();
        stream(400, int'(NP) - 1);
        idle(3);
        chk("partial_no_start", 128'(obs_starts), 128'(0));
        stream(415, 1);
        idle(2);
        chk("full_after_rst_start", 128'(obs_starts), 128'(1));
        chk_data("full_after_rst_data", bus.input_pes_data, ramp(400));
        idle(4);

        // 7) random traffic: 50% valid, occasional cfg with rare illegal fields
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rc = '0;
            for (int p = 0; p < int'(NP); p++) begin
                if ($urandom_range(31) == 0) begin
                    fv = int'($urandom_range(31));
                    while (legal_field(fv)) fv = int'($urandom_range(31));
                end else begin
                    fv = 1 << $urandom_range(NL);
                end
                rc[p*GSW +: GSW] = GSW'(fv);
            end
            cyc(1'($urandom_range(1)), rand_word(), ($urandom_range(7) == 0), rc, 1'b0, acc);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
